// File: rtl/ternary_pkg.sv
// Shared types and helpers for the ternary weight loader.
// State encoding, weight width and row addressing.
package ternary_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int W_BITS = 2;

  localparam logic [W_BITS-1:0] ZERO = 2'b00;
  localparam logic [W_BITS-1:0] POS  = 2'b01;
  localparam logic [W_BITS-1:0] NEG  = 2'b11;

  function automatic int row_offset(
    input int i,
    input int out_len
  );
    return i * W_BITS * out_len;
  endfunction

endpackage

// File: rtl/ternary_load_chk.sv
// Running XOR of accepted data beats and compare against a checksum beat.
// Only instantiated when LOAD_CHECKSUM_EN is defined.
module ternary_load_chk
  import ternary_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         acc,
  input  logic [W-1:0] data,
  output logic         match
);

  logic [W-1:0] xor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else if (clr) begin
      xor_q <= '0;
    end else if (acc) begin
      xor_q <= xor_q ^ data;
    end
  end

  assign match = (data == xor_q);

endmodule

// File: rtl/ternary_weight_loader.sv
// Ternary weight bank loader: start, one bit-slice per beat, done pulse.
// Optional LOAD_CHECKSUM_EN adds a trailing XOR checksum beat.
module ternary_weight_loader
  import ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ena,
  input  logic                                  start,
  input  logic [MAX_IN_LEN-1:0]                 in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]   uo_weights,
  output logic                                  uo_done,
  output logic                                  uo_busy,
`ifdef LOAD_CHECKSUM_EN
  output logic                                  uo_chk_err,
`endif
  output logic                                  uo_weights_valid
);

  localparam int BEATS = W_BITS * MAX_OUT_LEN;
  localparam int CNT_W = $clog2(BEATS);
  localparam int BANK  = 2 * MAX_IN_LEN * MAX_OUT_LEN;
  localparam int IDX_W = $clog2(BANK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] count, cnt_d;
  logic             wr;
  logic             start_acc;
  logic             set_wv;

`ifdef LOAD_CHECKSUM_EN
  logic chk_hs;
  logic chk_match;
  logic chk_err_q;

  ternary_load_chk #(
    .W (MAX_IN_LEN)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .acc   (wr),
    .data  (in_data),
    .match (chk_match)
  );

  assign uo_chk_err = chk_err_q;
`endif

  always_comb begin
    state_d   = state;
    cnt_d     = count;
    in_ready  = 1'b0;
    uo_done   = 1'b0;
    wr        = 1'b0;
    start_acc = 1'b0;
    set_wv    = 1'b0;
`ifdef LOAD_CHECKSUM_EN
    chk_hs    = 1'b0;
`endif
    if (ena) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d   = LOAD;
            cnt_d     = '0;
            start_acc = 1'b1;
          end
        end
        LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            wr = 1'b1;
            if (count == LAST) begin
              cnt_d = '0;
`ifdef LOAD_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end else begin
              cnt_d = count + 1'b1;
            end
          end
        end
        CHK: begin
`ifdef LOAD_CHECKSUM_EN
          in_ready = 1'b1;
          if (in_valid) begin
            chk_hs  = 1'b1;
            state_d = DONE;
          end
`else
          state_d = IDLE;
`endif
        end
        DONE: begin
          uo_done = 1'b1;
          state_d = IDLE;
`ifdef LOAD_CHECKSUM_EN
          // a failed checksum still pulses done but never validates the bank
          set_wv  = ~chk_err_q;
`else
          set_wv  = 1'b1;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign uo_busy = (state == LOAD) || (state == CHK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_weights_valid <= 1'b0;
    end else if (start_acc) begin
      uo_weights_valid <= 1'b0;
    end else if (set_wv) begin
      uo_weights_valid <= 1'b1;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else if (start_acc) begin
      chk_err_q <= 1'b0;
    end else if (chk_hs && !chk_match) begin
      chk_err_q <= 1'b1;
    end
  end
`endif

  // stale bits are never cleared on start; each beat overwrites its column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_weights <= '0;
    end else if (wr) begin
      for (int i = 0; i < MAX_IN_LEN; i++) begin
        uo_weights[IDX_W'(row_offset(i, MAX_OUT_LEN) + int'(count))]
          <= in_data[i];
      end
    end
  end

endmodule
